// File: rtl/alu_arbiter.sv
// Two-port front end that shares a single ALU between the EXU (port 0) and the
// branch/CSR unit (port 1); round-robin grant feeding a one-entry result register.
`ifndef XLEN
`define XLEN 64
`endif
`ifndef ALUOP_LEN
`define ALUOP_LEN 5
`endif
`ifndef ALUOP_ADD
`define ALUOP_ADD   5'd0
`define ALUOP_SUB   5'd1
`define ALUOP_AND   5'd2
`define ALUOP_OR    5'd3
`define ALUOP_XOR   5'd4
`define ALUOP_SLL   5'd5
`define ALUOP_SRL   5'd6
`define ALUOP_SRA   5'd7
`define ALUOP_SLT   5'd8
`define ALUOP_SLTU  5'd9
`define ALUOP_SLTI  5'd10
`define ALUOP_SLTIU 5'd11
`define ALUOP_BEQ   5'd12
`define ALUOP_BNE   5'd13
`define ALUOP_BLT   5'd14
`define ALUOP_BGE   5'd15
`define ALUOP_BLTU  5'd16
`define ALUOP_BGEU  5'd17
`endif

module alu #(
    parameter int XLEN      = `XLEN,
    parameter int ALUOP_LEN = `ALUOP_LEN
) (
    input  logic [ALUOP_LEN-1:0] op,
    input  logic [XLEN-1:0]      a,
    input  logic [XLEN-1:0]      b,
    output logic [XLEN-1:0]      result,
    output logic                 cmp
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] arith_s;
    logic            is_cmp_s;
    logic            lt_s;
    logic            ltu_s;
    logic            eq_s;

    // Arithmetic/logic result plus the compare flag; compare ops return the flag as a value.
    always_comb begin
        arith_s  = {XLEN{1'b0}};
        cmp      = 1'b0;
        is_cmp_s = 1'b0;
        lt_s     = ($signed(a) < $signed(b));
        ltu_s    = (a < b);
        eq_s     = (a == b);
        case (op)
            `ALUOP_ADD:   arith_s = a + b;
            `ALUOP_SUB:   arith_s = a - b;
            `ALUOP_AND:   arith_s = a & b;
            `ALUOP_OR:    arith_s = a | b;
            `ALUOP_XOR:   arith_s = a ^ b;
            `ALUOP_SLL:   arith_s = a << b[SHW-1:0];
            `ALUOP_SRL:   arith_s = a >> b[SHW-1:0];
            `ALUOP_SRA:   arith_s = $signed(a) >>> b[SHW-1:0];
            `ALUOP_SLT,
            `ALUOP_SLTI:  begin cmp = lt_s;   is_cmp_s = 1'b1; end
            `ALUOP_SLTU,
            `ALUOP_SLTIU: begin cmp = ltu_s;  is_cmp_s = 1'b1; end
            `ALUOP_BEQ:   begin cmp = eq_s;   is_cmp_s = 1'b1; end
            `ALUOP_BNE:   begin cmp = !eq_s;  is_cmp_s = 1'b1; end
            `ALUOP_BLT:   begin cmp = lt_s;   is_cmp_s = 1'b1; end
            `ALUOP_BGE:   begin cmp = !lt_s;  is_cmp_s = 1'b1; end
            `ALUOP_BLTU:  begin cmp = ltu_s;  is_cmp_s = 1'b1; end
            `ALUOP_BGEU:  begin cmp = !ltu_s; is_cmp_s = 1'b1; end
            default:      arith_s = {XLEN{1'b0}};
        endcase
        result = is_cmp_s ? {{(XLEN-1){1'b0}}, cmp} : arith_s;
    end
endmodule

module alu_arbiter #(
    parameter int XLEN      = `XLEN,
    parameter int ALUOP_LEN = `ALUOP_LEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [XLEN-1:0]      req0_a,
    input  logic [XLEN-1:0]      req0_b,
    input  logic [ALUOP_LEN-1:0] req0_op,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [XLEN-1:0]      req1_a,
    input  logic [XLEN-1:0]      req1_b,
    input  logic [ALUOP_LEN-1:0] req1_op,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [XLEN-1:0]      rsp0_result,
    output logic                 rsp0_cmp,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [XLEN-1:0]      rsp1_result,
    output logic                 rsp1_cmp
);
    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            prio_q, prio_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            cmp_q, cmp_d;

    logic                 grant_s;
    logic                 drain_s;
    logic                 free_s;
    logic                 xfer_s;
    logic [ALUOP_LEN-1:0] alu_op_s;
    logic [XLEN-1:0]      alu_a_s;
    logic [XLEN-1:0]      alu_b_s;
    logic [XLEN-1:0]      alu_result_s;
    logic                 alu_cmp_s;

    // Lone requester wins outright; on contention the priority pointer decides.
    always_comb begin
        grant_s = prio_q;
        if (req0_valid && !req1_valid) begin
            grant_s = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = prio_q;
        end
    end

    assign alu_op_s = grant_s ? req1_op : req0_op;
    assign alu_a_s  = grant_s ? req1_a  : req0_a;
    assign alu_b_s  = grant_s ? req1_b  : req0_b;

    alu #(.XLEN(XLEN), .ALUOP_LEN(ALUOP_LEN)) u_alu (
        .op     (alu_op_s),
        .a      (alu_a_s),
        .b      (alu_b_s),
        .result (alu_result_s),
        .cmp    (alu_cmp_s)
    );

    // Output register can take new data when empty or drained by its owner this cycle.
    assign drain_s    = (state_q == ST_FULL) && (owner_q ? rsp1_ready : rsp0_ready);
    assign free_s     = (state_q == ST_EMPTY) || drain_s;
    assign req0_ready = rst_n && free_s && req0_valid && !grant_s;
    assign req1_ready = rst_n && free_s && req1_valid && grant_s;
    assign xfer_s     = req0_ready || req1_ready;

    // Next-state for the output stage and the round-robin pointer.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        prio_d   = prio_q;
        result_d = result_q;
        cmp_d    = cmp_q;
        if (xfer_s) begin
            state_d  = ST_FULL;
            owner_d  = grant_s;
            prio_d   = !grant_s;
            result_d = alu_result_s;
            cmp_d    = alu_cmp_s;
        end else if (drain_s) begin
            state_d  = ST_EMPTY;
        end else begin
            state_d  = state_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            owner_q  <= 1'b0;
            prio_q   <= 1'b0;
            result_q <= {XLEN{1'b0}};
            cmp_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            prio_q   <= prio_d;
            result_q <= result_d;
            cmp_q    <= cmp_d;
        end
    end

    // Only the owner sees the held result; the other port reads zero.
    assign rsp0_valid  = rst_n && (state_q == ST_FULL) && !owner_q;
    assign rsp1_valid  = rst_n && (state_q == ST_FULL) && owner_q;
    assign rsp0_result = rsp0_valid ? result_q : {XLEN{1'b0}};
    assign rsp1_result = rsp1_valid ? result_q : {XLEN{1'b0}};
    assign rsp0_cmp    = rsp0_valid && cmp_q;
    assign rsp1_cmp    = rsp1_valid && cmp_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: expected responses are queued when a transfer is
// expected and compared when the owning port shows a valid result.
module tb_alu_arbiter;
    localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4,  OP_SLL  = 5'd5,  OP_SRL  = 5'd6,  OP_SRA  = 5'd7;
    localparam logic [4:0] OP_SLT  = 5'd8,  OP_SLTU = 5'd9,  OP_SLTI = 5'd10, OP_SLTIU = 5'd11;
    localparam logic [4:0] OP_BEQ  = 5'd12, OP_BNE  = 5'd13, OP_BLT  = 5'd14, OP_BGE  = 5'd15;
    localparam logic [4:0] OP_BLTU = 5'd16, OP_BGEU = 5'd17;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp0_cmp, rsp1_valid, rsp1_ready, rsp1_cmp;
    logic [63:0] rsp0_result, rsp1_result;

    typedef struct packed {
        logic        port;
        logic [63:0] res;
        logic        cmp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   stepno = 0;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_cmp(rsp0_cmp),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_cmp(rsp1_cmp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog step=%0d observed=timeout expected=finish", stepno);
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t model(input logic port, input logic [4:0] op,
                                   input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        logic        c;
        logic        sc;
        logic        lt;
        logic        ltu;
        logic [63:0] r;
        c   = 1'b0;
        sc  = 1'b1;
        r   = 64'd0;
        ltu = (a < b);
        lt  = (a[63] != b[63]) ? a[63] : ltu;
        case (op)
            OP_ADD:  begin r = a + b;            sc = 1'b0; end
            OP_SUB:  begin r = a + ~b + 64'd1;   sc = 1'b0; end
            OP_AND:  begin r = a & b;            sc = 1'b0; end
            OP_OR:   begin r = a | b;            sc = 1'b0; end
            OP_XOR:  begin r = a ^ b;            sc = 1'b0; end
            OP_SLL:  begin r = a << b[5:0];      sc = 1'b0; end
            OP_SRL:  begin r = a >> b[5:0];      sc = 1'b0; end
            OP_SRA:  begin
                r = a >> b[5:0];
                for (int i = 0; i < 64; i++) if (a[63] && (i >= 64 - int'(b[5:0]))) r[i] = 1'b1;
                sc = 1'b0;
            end
            OP_SLT, OP_SLTI, OP_BLT:    c = lt;
            OP_SLTU, OP_SLTIU, OP_BLTU: c = ltu;
            OP_BEQ:  c = (a == b);
            OP_BNE:  c = (a != b);
            OP_BGE:  c = !lt;
            OP_BGEU: c = !ltu;
            default: sc = 1'b0;
        endcase
        e.port = port;
        e.cmp  = c;
        e.res  = sc ? {63'd0, c} : r;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%h expected=%h", tag, stepno, obs, exp);
        end
    endtask

    task automatic drv0(input logic v, input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic drv1(input logic v, input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    endtask

    // One clock: check readies and response, update scoreboard, advance past the edge.
    task automatic step(input logic r0, input logic r1, input logic e0, input logic e1);
        exp_t h;
        stepno++;
        rsp0_ready = r0;
        rsp1_ready = r1;
        #1;
        chk("req0_ready", {63'd0, req0_ready}, {63'd0, e0});
        chk("req1_ready", {63'd0, req1_ready}, {63'd0, e1});
        if (!rst_n || sb.size() == 0) begin
            chk("rsp0_valid_idle", {63'd0, rsp0_valid}, 64'd0);
            chk("rsp1_valid_idle", {63'd0, rsp1_valid}, 64'd0);
            chk("rsp0_result_idle", rsp0_result, 64'd0);
            chk("rsp1_result_idle", rsp1_result, 64'd0);
            sb.delete();
        end else begin
            h = sb[0];
            if (h.port) begin
                chk("rsp1_valid", {63'd0, rsp1_valid}, 64'd1);
                chk("rsp1_result", rsp1_result, h.res);
                chk("rsp1_cmp", {63'd0, rsp1_cmp}, {63'd0, h.cmp});
                chk("rsp0_valid_other", {63'd0, rsp0_valid}, 64'd0);
                chk("rsp0_result_other", rsp0_result, 64'd0);
            end else begin
                chk("rsp0_valid", {63'd0, rsp0_valid}, 64'd1);
                chk("rsp0_result", rsp0_result, h.res);
                chk("rsp0_cmp", {63'd0, rsp0_cmp}, {63'd0, h.cmp});
                chk("rsp1_valid_other", {63'd0, rsp1_valid}, 64'd0);
                chk("rsp1_result_other", rsp1_result, 64'd0);
            end
            if (h.port ? r1 : r0) void'(sb.pop_front());
        end
        if (rst_n && req0_valid && e0) sb.push_back(model(1'b0, req0_op, req0_a, req0_b));
        if (rst_n && req1_valid && e1) sb.push_back(model(1'b1, req1_op, req1_a, req1_b));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        drv0(1'b1, OP_ADD, 64'd1, 64'd2);
        drv1(1'b1, OP_ADD, 64'd3, 64'd4);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;

        // ADD 5+7 on port 0, one-cycle latency
        drv0(1'b1, OP_ADD, 64'd5, 64'd7); drv1(1'b0, OP_ADD, 64'd0, 64'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        drv0(1'b0, OP_ADD, 64'd0, 64'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // SLTU on port 1 held for three stalled cycles, then drained
        drv1(1'b1, OP_SLTU, 64'd1, ONES);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        drv1(1'b0, OP_ADD, 64'd0, 64'd0); drv0(1'b1, OP_ADD, 64'd9, 64'd9);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        drv0(1'b0, OP_ADD, 64'd0, 64'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);

        // Both valid every cycle: grants alternate starting with port 0
        drv0(1'b1, OP_BLT, ONES, 64'd1); drv1(1'b1, OP_XOR, 64'hF0F0, 64'h0FF0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        drv0(1'b1, OP_SLL, 64'd3, 64'd4);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        drv1(1'b1, OP_BGEU, 64'd2, 64'd7);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        drv0(1'b1, OP_SRL, ONES, 64'd60);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        drv0(1'b0, OP_ADD, 64'd0, 64'd0); drv1(1'b0, OP_ADD, 64'd0, 64'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);

        // Drain of owner 0 and new port-1 SUB in the same cycle
        drv0(1'b1, OP_AND, 64'hFF00, 64'h0FF0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        drv0(1'b0, OP_ADD, 64'd0, 64'd0); drv1(1'b1, OP_SUB, 64'd3, 64'd5);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        drv1(1'b0, OP_ADD, 64'd0, 64'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);

        // Reset while FULL discards the result and restores port-0 priority
        drv0(1'b1, OP_ADD, 64'd100, 64'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        drv1(1'b1, OP_OR, 64'h5, 64'hA);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        drv0(1'b0, OP_ADD, 64'd0, 64'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        drv0(1'b1, OP_BEQ, 64'd8, 64'd8); drv1(1'b1, OP_SLT, ONES, 64'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        drv0(1'b0, OP_ADD, 64'd0, 64'd0); drv1(1'b0, OP_ADD, 64'd0, 64'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);

        // Arithmetic shift of the sign bit all the way down
        drv0(1'b1, OP_SRA, 64'h8000_0000_0000_0000, 64'd63);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        drv0(1'b0, OP_ADD, 64'd0, 64'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
